// File: rtl/key_schedule_sequencer.sv
// Iterative AES-128 key schedule: one round key per cycle into an 11-entry store, read back through a registered port.
// Optional build macro KEY_SCHED_FULL_OUT_EN adds the flat 1408-bit roundKeys output.
module key_schedule_sequencer (
  input  logic         clock,
  input  logic         reset,
  input  logic         keyValid,
  output logic         keyReady,
  input  logic [127:0] key,
  output logic         keysValid,
  input  logic [3:0]   rdIndex,
  output logic [127:0] rdKey
`ifdef KEY_SCHED_FULL_OUT_EN
  ,
  output logic [1407:0] roundKeys
`endif
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[8 * (255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t       state;
  logic [3:0]   roundCnt;
  logic [7:0]   rcon;
  logic [127:0] store [0:10];

  logic [3:0]   prev_idx;
  logic [127:0] prev_key;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  w0n, w1n, w2n, w3n;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    prev_idx = roundCnt - 4'd1;
    prev_key = '0;
    if (prev_idx <= 4'd10) prev_key = store[prev_idx];
  end

  // Four S-box lookups, reused by every round of the expansion.
  assign rot_word = {prev_key[23:0], prev_key[31:24]};
  assign sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                     sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
  assign w0n = prev_key[127:96] ^ sub_word ^ {rcon, 24'h0};
  assign w1n = prev_key[95:64] ^ w0n;
  assign w2n = prev_key[63:32] ^ w1n;
  assign w3n = prev_key[31:0]  ^ w2n;

  // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      roundCnt  <= 4'd0;
      rcon      <= 8'h00;
      keyReady  <= 1'b1;
      keysValid <= 1'b0;
      rdKey     <= '0;
      // NOTE: the store is cleared on reset so an aborted expansion leaves no partial keys readable.
      for (int i = 0; i <= 10; i++) store[i] <= '0;
    end else begin
      rdKey <= (rdIndex <= 4'd10) ? store[rdIndex] : '0;
      case (state)
        IDLE, READY: begin
          if (keyValid) begin
            store[0]  <= key;
            roundCnt  <= 4'd1;
            rcon      <= 8'h01;
            state     <= EXPAND;
            keyReady  <= 1'b0;
            keysValid <= 1'b0;
          end
        end
        EXPAND: begin
          store[roundCnt] <= {w0n, w1n, w2n, w3n};
          rcon            <= xtime(rcon);
          if (roundCnt == 4'd10) begin
            state     <= READY;
            keyReady  <= 1'b1;
            keysValid <= 1'b1;
          end else begin
            roundCnt <= roundCnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEY_SCHED_FULL_OUT_EN
  // store[0] lands in the MSBs, matching the combinational expander layout.
  for (genvar g = 0; g <= 10; g++) begin : g_flat
    assign roundKeys[1407 - 128 * g -: 128] = store[g];
  end
`else
  // Default build: round keys leave the block only through rdKey.
`endif

endmodule

// File: tb/tb_key_schedule_sequencer.sv
// Directed bench for key_schedule_sequencer using FIPS-197 vectors, handshake, reset-abort and read-port cases.
module tb_key_schedule_sequencer;

  logic         clock = 1'b0;
  logic         reset;
  logic         keyValid;
  logic         keyReady;
  logic [127:0] key;
  logic         keysValid;
  logic [3:0]   rdIndex;
  logic [127:0] rdKey;
`ifdef KEY_SCHED_FULL_OUT_EN
  logic [1407:0] roundKeys;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEYX = 128'hffeeddccbbaa99887766554433221100;

  logic [127:0] rk1 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  key_schedule_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .keyValid  (keyValid),
    .keyReady  (keyReady),
    .key       (key),
    .keysValid (keysValid),
    .rdIndex   (rdIndex),
    .rdKey     (rdKey)
`ifdef KEY_SCHED_FULL_OUT_EN
    ,
    .roundKeys (roundKeys)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_keys_valid(input string tag);
    int cnt = 0;
    while (!keysValid && cnt < 20) begin
      step();
      cnt++;
    end
    check(tag, 128'(cnt), 128'd10);
  endtask

  task automatic read_check(input string tag, input logic [3:0] idx, input logic [127:0] exp);
    rdIndex = idx;
    step();
    check(tag, rdKey, exp);
  endtask

  initial begin
    reset = 1'b1; keyValid = 1'b0; key = '0; rdIndex = 4'd0;
    step(); step();
    check("reset_keyReady", 128'(keyReady), 128'd1);
    check("reset_keysValid", 128'(keysValid), 128'd0);
    check("reset_rdKey", rdKey, 128'h0);
    reset = 1'b0;
    read_check("idle_store0_zero", 4'd0, 128'h0);

    // FIPS-197 vector: one-cycle keyValid pulse, keysValid exactly 10 edges later.
    key = KEY1; keyValid = 1'b1;
    step();
    keyValid = 1'b0;
    check("accept_keyReady_low", 128'(keyReady), 128'd0);
    wait_keys_valid("fips_latency");
    check("fips_keyReady_high", 128'(keyReady), 128'd1);
    read_check("fips_rd1", 4'd1, rk1[1]);
    read_check("fips_rd10", 4'd10, rk1[10]);
    read_check("fips_rd0", 4'd0, KEY1);

    // Consecutive-cycle sweep: each rdKey reflects the index set one edge earlier.
    for (int i = 0; i <= 10; i++) begin
      rdIndex = 4'(i);
      step();
      check($sformatf("sweep_rd%0d", i), rdKey, rk1[i]);
    end
    for (int i = 11; i <= 15; i++) begin
      rdIndex = 4'(i);
      step();
      check($sformatf("oob_rd%0d", i), rdKey, 128'h0);
    end
`ifdef KEY_SCHED_FULL_OUT_EN
    check("full_out_last", roundKeys[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int i = 0; i <= 10; i++)
      check($sformatf("full_out_%0d", i), roundKeys[1407 - 128 * i -: 128], rk1[i]);
`endif

    // Handshake: keyValid held with another key during EXPAND must be ignored.
    key = KEY1; keyValid = 1'b1;
    step();
    key = KEYX;
    for (int i = 1; i <= 9; i++) begin
      check($sformatf("hs_keyReady_c%0d", i), 128'(keyReady), 128'd0);
      step();
    end
    keyValid = 1'b0;
    check("hs_keysValid_pre", 128'(keysValid), 128'd0);
    step();
    check("hs_keysValid", 128'(keysValid), 128'd1);
    read_check("hs_rd0", 4'd0, KEY1);
    read_check("hs_rd10", 4'd10, rk1[10]);

    // New key in READY restarts expansion and drops keysValid on the acceptance edge.
    key = KEY2; keyValid = 1'b1;
    step();
    keyValid = 1'b0;
    check("rekey_keysValid_drop", 128'(keysValid), 128'd0);
    check("rekey_keyReady_drop", 128'(keyReady), 128'd0);
    wait_keys_valid("rekey_latency");
    read_check("rekey_rd10", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    read_check("rekey_rd0", 4'd0, KEY2);

    // Reset after 5 expansion edges clears every entry.
    key = KEY1; keyValid = 1'b1;
    step();
    keyValid = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_keysValid", 128'(keysValid), 128'd0);
    check("abort_keyReady", 128'(keyReady), 128'd1);
    for (int i = 0; i <= 10; i++) begin
      rdIndex = 4'(i);
      step();
      check($sformatf("abort_rd%0d", i), rdKey, 128'h0);
    end
    check("abort_keysValid_hold", 128'(keysValid), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
